// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters (CPU MEM stage on A, loader/debug on B),
// the data-memory arbiter and the single-port data memory.
interface dmem_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic              a_err;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic              b_err;
    logic [DATA_W-1:0] b_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    // Arbiter side
    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_err, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_err, b_rdata,
        output mem_addr, mem_wdata, mem_write, mem_read,
        input  mem_rdata,
        output busy
    );

    // Requester/memory side
    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_err, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_err, b_rdata,
        input  mem_addr, mem_wdata, mem_write, mem_read,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between port A (CPU)
// and port B (loader/debug); fixed-latency strobe sequencing, no caching.
module dmem_arbiter #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic {
        PORT_A,
        PORT_B
    } port_t;

    localparam int unsigned       CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(MEM_LATENCY - 1);
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

    state_t            state_q,     state_d;
    port_t             gnt_q,       gnt_d;
    port_t             last_q,      last_d;
    logic              we_q,        we_d;
    logic              err_q,       err_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] a_rdata_q,   a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q,   b_rdata_d;

    port_t             sel_port;
    logic              req_any;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              in_range;

    // B wins only when A is idle or A had the previous grant.
    always_comb begin
        req_any   = bus.a_req || bus.b_req;
        sel_port  = (bus.b_req && (!bus.a_req || last_q == PORT_A)) ? PORT_B : PORT_A;
        sel_we    = (sel_port == PORT_B) ? bus.b_we    : bus.a_we;
        sel_addr  = (sel_port == PORT_B) ? bus.b_addr  : bus.a_addr;
        sel_wdata = (sel_port == PORT_B) ? bus.b_wdata : bus.a_wdata;
        in_range  = {1'b0, sel_addr} < DEPTH_X;
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        we_d        = we_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    gnt_d  = sel_port;
                    last_d = sel_port;
                    we_d   = sel_we;
                    err_d  = !in_range;
                    cnt_d  = CNT_INIT;
                    if (in_range) begin
                        // Memory-side address/data only move on real accesses.
                        mem_addr_d  = sel_addr;
                        mem_wdata_d = sel_wdata;
                        state_d     = ACCESS;
                    end else begin
                        state_d = RESP;
                        if (!sel_we) begin
                            if (sel_port == PORT_B) b_rdata_d = '0;
                            else                    a_rdata_d = '0;
                        end
                    end
                end
            end

            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (!we_q) begin
                        if (gnt_q == PORT_B) b_rdata_d = bus.mem_rdata;
                        else                 a_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= PORT_A;
            last_q      <= PORT_B;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            we_q        <= we_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
        end
    end

    assign bus.a_ack     = (state_q == RESP) && (gnt_q == PORT_A);
    assign bus.b_ack     = (state_q == RESP) && (gnt_q == PORT_B);
    assign bus.a_err     = bus.a_ack && err_q;
    assign bus.b_err     = bus.b_ack && err_q;
    assign bus.a_rdata   = a_rdata_q;
    assign bus.b_rdata   = b_rdata_q;

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_write = (state_q == ACCESS) && we_q;
    assign bus.mem_read  = (state_q == ACCESS) && !we_q;

    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance at MEM_LATENCY=1 and one at 3,
// each backed by a 256-word memory preloaded with mem[i] = i.
module tb_dmem_arbiter;

    logic clk;
    logic rst;

    int total;
    int bad;

    dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus1 ();
    dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus3 ();

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .MEM_LATENCY(1)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .MEM_LATENCY(3)) u3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem1[i] <= 32'(i);
        end else if (bus1.mem_write) begin
            mem1[bus1.mem_addr[7:0]] <= bus1.mem_wdata;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem3[i] <= 32'(i);
        end else if (bus3.mem_write) begin
            mem3[bus3.mem_addr[7:0]] <= bus3.mem_wdata;
        end
    end

    assign bus1.mem_rdata = mem1[bus1.mem_addr[7:0]];
    assign bus3.mem_rdata = mem3[bus3.mem_addr[7:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int rd_cycles;
        int busy_cycles;
        int ack_at;
        logic exp_b;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus1.a_req = 1'b0; bus1.a_we = 1'b0; bus1.a_addr = '0; bus1.a_wdata = '0;
        bus1.b_req = 1'b0; bus1.b_we = 1'b0; bus1.b_addr = '0; bus1.b_wdata = '0;
        bus3.a_req = 1'b0; bus3.a_we = 1'b0; bus3.a_addr = '0; bus3.a_wdata = '0;
        bus3.b_req = 1'b0; bus3.b_we = 1'b0; bus3.b_addr = '0; bus3.b_wdata = '0;

        tick();
        tick();
        chk("rst_busy",     32'(bus1.busy),      32'd0);
        chk("rst_a_ack",    32'(bus1.a_ack),     32'd0);
        chk("rst_b_ack",    32'(bus1.b_ack),     32'd0);
        chk("rst_a_err",    32'(bus1.a_err),     32'd0);
        chk("rst_a_rdata",  bus1.a_rdata,        32'd0);
        chk("rst_b_rdata",  bus1.b_rdata,        32'd0);
        chk("rst_mem_addr", bus1.mem_addr,       32'd0);
        chk("rst_mem_wd",   bus1.mem_wdata,      32'd0);
        chk("rst_mem_rd",   32'(bus1.mem_read),  32'd0);
        chk("rst_mem_wr",   32'(bus1.mem_write), 32'd0);
        rst = 1'b0;
        tick();

        // Single read on A, latency 1
        bus1.a_req = 1'b1; bus1.a_we = 1'b0; bus1.a_addr = 32'd10;
        tick();
        chk("rd_access_read", 32'(bus1.mem_read),  32'd1);
        chk("rd_access_wr",   32'(bus1.mem_write), 32'd0);
        chk("rd_access_addr", bus1.mem_addr,       32'd10);
        chk("rd_access_busy", 32'(bus1.busy),      32'd1);
        chk("rd_access_ack",  32'(bus1.a_ack),     32'd0);
        tick();
        chk("rd_resp_ack",   32'(bus1.a_ack),    32'd1);
        chk("rd_resp_err",   32'(bus1.a_err),    32'd0);
        chk("rd_resp_rdata", bus1.a_rdata,       32'd10);
        chk("rd_resp_b_ack", 32'(bus1.b_ack),    32'd0);
        chk("rd_resp_read",  32'(bus1.mem_read), 32'd0);
        bus1.a_req = 1'b0;
        tick();
        chk("rd_idle_ack",  32'(bus1.a_ack), 32'd0);
        chk("rd_idle_busy", 32'(bus1.busy),  32'd0);

        // Write then read on B
        bus1.b_req = 1'b1; bus1.b_we = 1'b1; bus1.b_addr = 32'd3; bus1.b_wdata = 32'hDEADBEEF;
        tick();
        chk("wr_access_wr",    32'(bus1.mem_write), 32'd1);
        chk("wr_access_rd",    32'(bus1.mem_read),  32'd0);
        chk("wr_access_addr",  bus1.mem_addr,       32'd3);
        chk("wr_access_wdata", bus1.mem_wdata,      32'hDEADBEEF);
        tick();
        chk("wr_resp_b_ack", 32'(bus1.b_ack),     32'd1);
        chk("wr_resp_a_ack", 32'(bus1.a_ack),     32'd0);
        chk("wr_resp_wr",    32'(bus1.mem_write), 32'd0);
        chk("wr_resp_rdata", bus1.b_rdata,        32'd0);
        bus1.b_we = 1'b0;
        tick();
        chk("wr_gap_busy", 32'(bus1.busy), 32'd0);
        tick();
        chk("rb_access_read", 32'(bus1.mem_read), 32'd1);
        tick();
        chk("rb_resp_ack",   32'(bus1.b_ack), 32'd1);
        chk("rb_resp_rdata", bus1.b_rdata,    32'hDEADBEEF);
        bus1.b_req = 1'b0;
        tick();

        // Contention: both requesting, last grant was B so A goes first
        bus1.a_req = 1'b1; bus1.a_we = 1'b0; bus1.a_addr = 32'd7;
        bus1.b_req = 1'b1; bus1.b_we = 1'b0; bus1.b_addr = 32'd8;
        for (int t = 0; t < 4; t++) begin
            exp_b = (t % 2) == 1;
            tick();
            chk("cont_addr", bus1.mem_addr, exp_b ? 32'd8 : 32'd7);
            chk("cont_read", 32'(bus1.mem_read), 32'd1);
            tick();
            chk("cont_a_ack", 32'(bus1.a_ack), 32'(!exp_b));
            chk("cont_b_ack", 32'(bus1.b_ack), 32'(exp_b));
            if (t == 3) begin
                bus1.a_req = 1'b0;
                bus1.b_req = 1'b0;
            end
            tick();
            chk("cont_idle_busy", 32'(bus1.busy), 32'd0);
        end
        chk("cont_a_rdata", bus1.a_rdata, 32'd7);
        chk("cont_b_rdata", bus1.b_rdata, 32'd8);

        // In-range boundary address 255
        bus1.a_req = 1'b1; bus1.a_we = 1'b0; bus1.a_addr = 32'd255;
        tick();
        chk("b255_read", 32'(bus1.mem_read), 32'd1);
        tick();
        chk("b255_err",   32'(bus1.a_err), 32'd0);
        chk("b255_rdata", bus1.a_rdata,    32'd255);
        bus1.a_req = 1'b0;
        tick();

        // Out of range read at 256: straight to RESP, rdata cleared
        bus1.a_req = 1'b1; bus1.a_we = 1'b0; bus1.a_addr = 32'd256;
        tick();
        chk("oor_ack",   32'(bus1.a_ack),     32'd1);
        chk("oor_err",   32'(bus1.a_err),     32'd1);
        chk("oor_read",  32'(bus1.mem_read),  32'd0);
        chk("oor_write", 32'(bus1.mem_write), 32'd0);
        chk("oor_rdata", bus1.a_rdata,        32'd0);
        chk("oor_addr",  bus1.mem_addr,       32'd255);
        bus1.a_req = 1'b0;
        tick();
        chk("oor_idle_ack", 32'(bus1.a_ack), 32'd0);
        chk("oor_idle_err", 32'(bus1.a_err), 32'd0);

        // Out of range write with only the top bit set: no memory update
        bus1.b_req = 1'b1; bus1.b_we = 1'b1; bus1.b_addr = 32'h8000_0003; bus1.b_wdata = 32'h1234_5678;
        tick();
        chk("oorw_ack",   32'(bus1.b_ack),     32'd1);
        chk("oorw_err",   32'(bus1.b_err),     32'd1);
        chk("oorw_write", 32'(bus1.mem_write), 32'd0);
        chk("oorw_rdata", bus1.b_rdata,        32'd8);
        bus1.b_req = 1'b0;
        tick();
        chk("oorw_mem3", mem1[3], 32'hDEADBEEF);

        // Latency 3 read at 20
        rd_cycles   = 0;
        busy_cycles = 0;
        ack_at      = 0;
        bus3.a_req = 1'b1; bus3.a_we = 1'b0; bus3.a_addr = 32'd20;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (bus3.mem_read) rd_cycles++;
            if (bus3.busy) busy_cycles++;
            if (bus3.a_ack && ack_at == 0) begin
                ack_at = i;
                bus3.a_req = 1'b0;
            end
        end
        chk("lat_read_cycles", 32'(rd_cycles),   32'd3);
        chk("lat_busy_cycles", 32'(busy_cycles), 32'd4);
        chk("lat_ack_at",      32'(ack_at),      32'd4);
        chk("lat_rdata",       bus3.a_rdata,     32'd20);

        // Reset during second ACCESS cycle
        bus3.a_req = 1'b1; bus3.a_we = 1'b0; bus3.a_addr = 32'd5;
        tick();
        chk("rmo_access1", 32'(bus3.mem_read), 32'd1);
        tick();
        chk("rmo_access2", 32'(bus3.mem_read), 32'd1);
        rst = 1'b1;
        tick();
        chk("rmo_read",  32'(bus3.mem_read),  32'd0);
        chk("rmo_write", 32'(bus3.mem_write), 32'd0);
        chk("rmo_busy",  32'(bus3.busy),      32'd0);
        chk("rmo_ack",   32'(bus3.a_ack),     32'd0);
        chk("rmo_rdata", bus3.a_rdata,        32'd0);
        rst = 1'b0;
        bus3.b_req = 1'b1; bus3.b_we = 1'b0; bus3.b_addr = 32'd6;
        tick();
        chk("rmo_tie_addr",  bus3.mem_addr,    32'd5);
        chk("rmo_tie_b_ack", 32'(bus3.b_ack),  32'd0);
        tick();
        tick();
        tick();
        chk("rmo_tie_a_ack", 32'(bus3.a_ack), 32'd1);
        chk("rmo_tie_b_no",  32'(bus3.b_ack), 32'd0);
        chk("rmo_tie_rdata", bus3.a_rdata,    32'd5);
        bus3.a_req = 1'b0;
        bus3.b_req = 1'b0;
        tick();
        chk("rmo_end_busy", 32'(bus3.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
